// File: rtl/sdram_qos_arb.sv
// sdram_qos_arb: shares one sdram_core_32bit request interface among NPORTS
// requesters. Fixed priority (port 0 highest) by default; ports stalled for
// MAX_WAIT cycles become urgent and are served round-robin. A tag FIFO steers
// in-order read acks back to the issuing port.
module sdram_qos_arb #(
  parameter int NPORTS   = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 64,
  parameter int RD_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NPORTS*ADDR_W-1:0]     req_addr,
  input  logic [NPORTS*DATA_W-1:0]     req_write_data,
  input  logic [NPORTS*DATA_W/8-1:0]   req_wr,
  input  logic [NPORTS-1:0]            req_rd,
  output logic [NPORTS-1:0]            req_accept,
  output logic [NPORTS-1:0]            req_ack,
  output logic [DATA_W-1:0]            req_read_data,
  output logic [ADDR_W-1:0]            core_addr,
  output logic [DATA_W-1:0]            core_write_data,
  output logic [DATA_W/8-1:0]          core_wr,
  output logic                         core_rd,
  input  logic                         core_accept,
  input  logic                         core_ack,
  input  logic [DATA_W-1:0]            core_read_data,
  output logic [$clog2(NPORTS)-1:0]    grant_id,
  output logic                         err_orphan_ack
);

  localparam int BE_W = DATA_W / 8;
  localparam int ID_W = $clog2(NPORTS);
  localparam int CW   = $clog2(MAX_WAIT + 1);
  localparam int PW   = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]        state;
  logic [ID_W-1:0]   lock_id;
  logic [ID_W-1:0]   rr_ptr;
  logic [CW-1:0]     wait_cnt [NPORTS];
  logic [ID_W-1:0]   tag_mem  [RD_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       tag_cnt;
  logic              fifo_full, fifo_empty;
  logic [NPORTS-1:0] is_wr, is_req, eligible, urgent;
  logic              win_vld, sel_vld, acc_fire, push, pop;
  logic [ID_W-1:0]   win_id, sel_id, head_tag;

  assign fifo_full  = (tag_cnt == (PW+1)'(RD_DEPTH));
  assign fifo_empty = (tag_cnt == '0);
  assign head_tag   = tag_mem[rd_ptr];

  // Per-port request decode: write wins over read, reads need a free tag slot
  always_comb begin
    for (int unsigned i = 0; i < NPORTS; i++) begin
      is_wr[i]    = |req_wr[i*BE_W +: BE_W];
      is_req[i]   = is_wr[i] | req_rd[i];
      eligible[i] = is_wr[i] | (req_rd[i] & ~fifo_full);
      urgent[i]   = (wait_cnt[i] == CW'(MAX_WAIT));
    end
  end

  // Winner selection: round-robin among urgent ports after rr_ptr, else lowest index
  always_comb begin
    logic [ID_W-1:0] idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    if (|(urgent & eligible)) begin
      for (int unsigned k = 1; k <= NPORTS; k++) begin
        idx = ID_W'((32'(rr_ptr) + k) % NPORTS);
        if (!win_vld && urgent[idx] && eligible[idx]) begin
          win_vld = 1'b1;
          win_id  = idx;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (!win_vld && eligible[i]) begin
          win_vld = 1'b1;
          win_id  = ID_W'(i);
        end
      end
    end
  end

  // Port presented to the core: locked port holds the bus until accepted
  always_comb begin
    if (state == S_LOCKED) begin
      sel_id  = lock_id;
      sel_vld = rst_n & is_req[lock_id];
    end else begin
      sel_id  = win_id;
      sel_vld = rst_n & win_vld;
    end
    core_addr       = sel_vld ? req_addr[int'(sel_id)*ADDR_W +: ADDR_W] : '0;
    core_write_data = sel_vld ? req_write_data[int'(sel_id)*DATA_W +: DATA_W] : '0;
    core_wr         = sel_vld ? req_wr[int'(sel_id)*BE_W +: BE_W] : '0;
    core_rd         = sel_vld & ~is_wr[sel_id] & req_rd[sel_id];
    grant_id        = sel_vld ? sel_id : '0;
    acc_fire        = sel_vld & core_accept;
    push            = acc_fire & core_rd;
    pop             = core_ack & ~fifo_empty;
    req_read_data   = core_read_data;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      req_accept[i] = acc_fire && (sel_id == ID_W'(i));
      req_ack[i]    = pop && (head_tag == ID_W'(i));
    end
  end

  // Arbitration FSM, wait counters and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      lock_id <= '0;
      rr_ptr  <= '0;
      for (int unsigned i = 0; i < NPORTS; i++) wait_cnt[i] <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (win_vld && !core_accept) begin
            lock_id <= win_id;
            state   <= S_LOCKED;
          end
        default:
          if (!is_req[lock_id] || core_accept) state <= S_IDLE;
      endcase
      if (acc_fire && urgent[sel_id]) rr_ptr <= sel_id;
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if ((acc_fire && sel_id == ID_W'(i)) || !is_req[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != CW'(MAX_WAIT))
          wait_cnt[i] <= wait_cnt[i] + CW'(1);
      end
    end
  end

  // Tag FIFO pointers, occupancy and sticky orphan-ack flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tag_cnt        <= '0;
      err_orphan_ack <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(RD_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(RD_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      tag_cnt <= tag_cnt + (PW+1)'(1);
      else if (pop && !push) tag_cnt <= tag_cnt - (PW+1)'(1);
      if (core_ack && fifo_empty) err_orphan_ack <= 1'b1;
    end
  end

  // Tag storage: contents are don't-care while unoccupied, so no reset
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= sel_id;
  end

endmodule

// File: tb/tb_sdram_qos_arb.sv
// Randomized and directed bench for sdram_qos_arb against a rule-level model.
module tb_sdram_qos_arb;
  localparam int NP  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int MW  = 8;
  localparam int RD  = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_write_data;
  logic [NP*BW-1:0]  req_wr;
  logic [NP-1:0]     req_rd;
  logic [NP-1:0]     req_accept, req_ack;
  logic [DW-1:0]     req_read_data;
  logic [AW-1:0]     core_addr;
  logic [DW-1:0]     core_write_data;
  logic [BW-1:0]     core_wr;
  logic              core_rd;
  logic              core_accept, core_ack;
  logic [DW-1:0]     core_read_data;
  logic [IDW-1:0]    grant_id;
  logic              err_orphan_ack;

  sdram_qos_arb #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .RD_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_write_data(req_write_data),
    .req_wr(req_wr), .req_rd(req_rd), .req_accept(req_accept), .req_ack(req_ack),
    .req_read_data(req_read_data), .core_addr(core_addr), .core_write_data(core_write_data),
    .core_wr(core_wr), .core_rd(core_rd), .core_accept(core_accept), .core_ack(core_ack),
    .core_read_data(core_read_data), .grant_id(grant_id), .err_orphan_ack(err_orphan_ack)
  );

  always #5 clk = ~clk;

  // Per-port stimulus
  logic [AW-1:0] p_addr [NP];
  logic [DW-1:0] p_data [NP];
  logic [BW-1:0] p_wr   [NP];
  logic          p_rd   [NP];

  // Reference model state
  int          wcnt [NP];
  int          rr;
  bit          locked;
  int          lock_port;
  int          tags [$];
  bit          orphan;
  logic [NP-1:0] m_acc;
  logic [NP-1:0] obs_acc;
  logic [AW-1:0] obs_addr;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit requesting(input int i);
    return (p_wr[i] != '0) || p_rd[i];
  endfunction

  function automatic bit elig(input int i);
    return (p_wr[i] != '0) || (p_rd[i] && tags.size() < RD);
  endfunction

  task automatic apply();
    for (int i = 0; i < NP; i++) begin
      req_addr[i*AW +: AW]       = p_addr[i];
      req_write_data[i*DW +: DW] = p_data[i];
      req_wr[i*BW +: BW]         = p_wr[i];
      req_rd[i]                  = p_rd[i];
    end
  endtask

  task automatic clear_ports();
    for (int i = 0; i < NP; i++) begin
      p_addr[i] = '0; p_data[i] = '0; p_wr[i] = '0; p_rd[i] = 1'b0;
    end
  endtask

  // One clock: compare outputs at negedge against the model, then advance it
  task automatic step();
    int ch, best, bestd, d;
    bit was_urg, is_read, acc;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [BW-1:0] e_wr;
    logic          e_rd;
    logic [NP-1:0] e_acc, e_ack;
    apply();
    @(negedge clk);
    obs_acc  = req_accept;
    obs_addr = core_addr;
    if (!rst_n) begin
      check_eq("rst_core_addr", core_addr, 0);
      check_eq("rst_core_wr", core_wr, 0);
      check_eq("rst_core_rd", core_rd, 0);
      check_eq("rst_core_wdata", core_write_data, 0);
      check_eq("rst_grant_id", grant_id, 0);
      check_eq("rst_req_accept", req_accept, 0);
      check_eq("rst_req_ack", req_ack, 0);
      check_eq("rst_orphan", err_orphan_ack, 0);
      tags.delete();
      for (int i = 0; i < NP; i++) wcnt[i] = 0;
      rr = 0; locked = 0; lock_port = 0; orphan = 0; m_acc = '0;
    end else begin
      ch = -1;
      if (locked) begin
        if (requesting(lock_port)) ch = lock_port;
      end else begin
        best = -1; bestd = NP;
        for (int i = 0; i < NP; i++) begin
          d = (i - rr - 1 + 2*NP) % NP;
          if (elig(i) && wcnt[i] == MW && d < bestd) begin best = i; bestd = d; end
        end
        if (best >= 0) ch = best;
        else for (int i = 0; i < NP; i++) if (ch < 0 && elig(i)) ch = i;
      end
      e_addr = '0; e_data = '0; e_wr = '0; e_rd = 1'b0; e_acc = '0; e_ack = '0;
      is_read = 1'b0; was_urg = 1'b0;
      if (ch >= 0) begin
        e_addr  = p_addr[ch];
        e_data  = p_data[ch];
        e_wr    = p_wr[ch];
        is_read = (p_wr[ch] == '0) && p_rd[ch];
        e_rd    = is_read;
        was_urg = (wcnt[ch] == MW);
      end
      acc = (ch >= 0) && core_accept;
      if (acc) e_acc[ch] = 1'b1;
      if (core_ack && tags.size() > 0) e_ack[tags[0]] = 1'b1;
      check_eq("core_addr", core_addr, e_addr);
      check_eq("core_wdata", core_write_data, e_data);
      check_eq("core_wr", core_wr, e_wr);
      check_eq("core_rd", core_rd, e_rd);
      check_eq("grant_id", grant_id, (ch >= 0) ? ch : 0);
      check_eq("req_accept", req_accept, e_acc);
      check_eq("req_ack", req_ack, e_ack);
      check_eq("req_rdata", req_read_data, core_read_data);
      check_eq("orphan", err_orphan_ack, orphan);
      if (core_ack) begin
        if (tags.size() > 0) void'(tags.pop_front());
        else orphan = 1'b1;
      end
      if (acc && is_read) tags.push_back(ch);
      for (int i = 0; i < NP; i++) begin
        if ((acc && i == ch) || !requesting(i)) wcnt[i] = 0;
        else if (wcnt[i] < MW) wcnt[i]++;
      end
      if (acc && was_urg) rr = ch;
      if (!locked) begin
        if (ch >= 0 && !core_accept) begin locked = 1'b1; lock_port = ch; end
      end else if (ch < 0 || core_accept) locked = 1'b0;
      m_acc = e_acc;
    end
    @(posedge clk);
    #1;
  endtask

  // Step and withdraw any request the model saw accepted
  task automatic hold_step();
    step();
    for (int i = 0; i < NP; i++) if (m_acc[i]) begin p_wr[i] = '0; p_rd[i] = 1'b0; end
  endtask

  task automatic drain();
    clear_ports();
    core_accept = 1'b0;
    for (int n = 0; n < 16 && tags.size() > 0; n++) begin
      core_ack = 1'b1;
      core_read_data = $urandom;
      step();
    end
    core_ack = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, cnt, rem;
    rst_n = 1'b0;
    core_accept = 1'b0; core_ack = 1'b0; core_read_data = '0;
    clear_ports();
    for (int i = 0; i < NP; i++) begin
      p_addr[i] = $urandom; p_wr[i] = 4'hF;
    end
    apply();
    step();
    step();
    clear_ports();
    rst_n = 1'b1;
    step();

    // Write path with a 3-cycle stall
    p_wr[0] = 4'hF; p_addr[0] = 32'h100; p_data[0] = 32'hDEADBEEF;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      core_accept = (c == 3);
      hold_step();
      check_eq("wp_addr_stable", obs_addr, 32'h100);
      if (obs_acc[0]) cnt++;
    end
    check_eq("wp_accept_on_4th", obs_acc, 4'b0001);
    core_accept = 1'b1;
    step();
    check_eq("wp_single_accept", cnt, 1);

    // Fixed priority between two reads
    p_rd[1] = 1'b1; p_addr[1] = 32'h1000;
    p_rd[2] = 1'b1; p_addr[2] = 32'h2000;
    hold_step();
    check_eq("prio_first", obs_acc, 4'b0010);
    hold_step();
    check_eq("prio_second", obs_acc, 4'b0100);
    core_accept = 1'b0;
    drain();

    // Starvation: port 3 must win after MAX_WAIT stalled cycles
    p_wr[0] = 4'hF; p_addr[0] = 32'h40;
    p_rd[3] = 1'b1; p_addr[3] = 32'h3000;
    core_accept = 1'b1;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (obs_acc[3] && lat < 0) lat = c;
      if (m_acc[3]) p_rd[3] = 1'b0;
    end
    check_eq("starve_latency", lat, MW);
    drain();

    // Lock hold: port 2 keeps the bus while stalled
    p_rd[2] = 1'b1; p_addr[2] = 32'h2222_0000;
    core_accept = 1'b0;
    hold_step();
    p_wr[0] = 4'hF; p_addr[0] = 32'h10;
    hold_step();
    check_eq("lock_hold_addr", obs_addr, 32'h2222_0000);
    hold_step();
    core_accept = 1'b1;
    hold_step();
    check_eq("lock_accept", obs_acc, 4'b0100);
    hold_step();
    check_eq("lock_next", obs_acc, 4'b0001);
    drain();

    // FIFO full: only RD reads accepted until an ack frees a slot
    core_accept = 1'b1;
    rem = 5; cnt = 0;
    for (int c = 0; c < 8; c++) begin
      p_rd[1] = (rem > 0); p_addr[1] = 32'h5000 + c;
      step();
      if (obs_acc[1]) cnt++;
      if (m_acc[1]) rem--;
    end
    check_eq("full_accepts", cnt, RD);
    p_wr[0] = 4'h3; p_addr[0] = 32'h77;
    hold_step();
    check_eq("full_write_ok", obs_acc, 4'b0001);
    core_ack = 1'b1; core_read_data = 32'hA5A5_0001;
    step();
    check_eq("full_blocked", obs_acc[1], 1'b0);
    core_ack = 1'b0;
    step();
    check_eq("full_after_ack", obs_acc[1], 1'b1);
    drain();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (m_acc[i] || !requesting(i)) begin
          p_wr[i] = '0; p_rd[i] = 1'b0;
          if ($urandom_range(0, 2) == 0) begin
            p_addr[i] = $urandom; p_data[i] = $urandom;
            case ($urandom_range(0, 3))
              0: p_wr[i] = 4'($urandom_range(1, 15));
              1: begin p_wr[i] = 4'($urandom_range(1, 15)); p_rd[i] = 1'b1; end
              default: p_rd[i] = 1'b1;
            endcase
          end
        end else if ($urandom_range(0, 63) == 0) begin
          p_wr[i] = '0; p_rd[i] = 1'b0;
        end
      end
      core_accept    = ($urandom_range(0, 2) != 0);
      core_ack       = (tags.size() > 0) && ($urandom_range(0, 1) == 1);
      core_read_data = $urandom;
      step();
    end
    drain();

    // Reset with reads outstanding, then a stray ack
    core_accept = 1'b1;
    p_rd[2] = 1'b1; p_addr[2] = 32'h9000;
    step();
    step();
    check_eq("orph_outstanding", tags.size(), 2);
    clear_ports();
    core_accept = 1'b0;
    do_reset();
    core_ack = 1'b1; core_read_data = 32'hBAD0_0000;
    step();
    core_ack = 1'b0;
    step();
    check_eq("orphan_set", err_orphan_ack, 1'b1);
    step();
    step();
    check_eq("orphan_sticky", err_orphan_ack, 1'b1);
    do_reset();
    step();
    check_eq("orphan_cleared", err_orphan_ack, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sdram_qos_arb.md
Name: sdram_qos_arb

Overview:
- N-port arbiter that shares the single sdram_core_32bit request interface between several requesters. Examples: CPU, video fetch, DMA.
- Default service is fixed priority with port 0 highest.
- Per-port wait counters promote starved ports to round-robin urgent service.
- A read-tag FIFO routes each core read ack back to the port that issued the read, with up to RD_DEPTH reads in flight.

Parameters:
NPORTS, 4, number of requester ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables = DATA_W/8)
MAX_WAIT, 64, stalled cycles before a port becomes urgent
RD_DEPTH, 4, max outstanding reads (power of 2)

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_addr  in  NPORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
req_write_data  in  NPORTS*DATA_W  per-port write data
req_wr  in  NPORTS*DATA_W/8  per-port byte-enable write strobe; nonzero = write request
req_rd  in  NPORTS  per-port read request
req_accept  out  NPORTS  request taken by core; one-hot or zero
req_ack  out  NPORTS  read data valid for that port; one-hot or zero
req_read_data  out  DATA_W  core read data, broadcast to all ports
core_addr  out  ADDR_W  to core
core_write_data  out  DATA_W  to core
core_wr  out  DATA_W/8  to core
core_rd  out  1  to core
core_accept  in  1  core took the presented request this cycle
core_ack  in  1  core read data valid
core_read_data  in  DATA_W  core read data
grant_id  out  $clog2(NPORTS)  port currently presented to core (debug)
err_orphan_ack  out  1  sticky: core_ack received with tag FIFO empty

Behaviour:
- Reset (rst_n low, async): all of the following clear.
  - req_accept=0, req_ack=0, core_wr=0, core_rd=0, core_addr=0, core_write_data=0, grant_id=0, err_orphan_ack=0.
  - Tag FIFO empty, all wait counters 0, rr pointer 0, state IDLE.
  - Reset mid-transfer discards outstanding tags; a later core_ack then sets err_orphan_ack.
- Request of port i: req_wr[i]!=0 or req_rd[i]. If both are set, forward as a write and ignore rd.
- A read request is eligible only if the tag FIFO is not full. Writes are always eligible.
- State IDLE:
  - Winner is chosen combinationally from eligible requests.
  - If any port is urgent: round-robin among urgent ports, starting at the index after the rr pointer.
  - Otherwise: lowest eligible index wins.
  - The winner's addr, data, wr and rd pass combinationally to core_*. grant_id = winner.
  - No eligible request: core_wr=0, core_rd=0, addr/data=0.
- Accept in IDLE: if core_accept is high the same cycle, req_accept[winner]=1 combinationally. Zero added latency; stay IDLE.
- Lock: if core_accept is low with a winner present, register the winner and go to LOCKED.
- State LOCKED:
  - Locked port's signals are muxed to core regardless of other requests. No re-arbitration until core_accept.
  - On core_accept: req_accept[lock]=1, return to IDLE.
  - If the locked port drops its request (protocol violation): return to IDLE next cycle with no accept.
- Accept bookkeeping: on every accept, that port's wait counter clears. If the port was urgent, rr pointer = that port.
- Wait counters:
  - Each cycle port i requests and is not accepted: counter increments, saturating at MAX_WAIT.
  - Counter clears when the request drops.
  - Port is urgent while its counter == MAX_WAIT.
- Tag FIFO:
  - Push the grant index on an accepted read.
  - Pop on core_ack; req_ack[head]=1 combinationally with core_ack. req_read_data = core_read_data.
  - Simultaneous push and pop in one cycle is legal; occupancy unchanged.
  - Full: read grants blocked. Empty + core_ack: no req_ack; err_orphan_ack set.
- Writes generate no ack and no tag.
- Core reads return in order; ack order equals accept order.

Test Plan:
- Write path: port 0 only; writes 0xDEADBEEF to 0x100 with core_accept low 3 cycles then high → core_* stable during stall; req_accept[0] for exactly 1 cycle on cycle 4; no req_ack.
- Fixed priority: ports 1 and 2 read in the same IDLE cycle → port 1 accepted first; port 2 next; acks arrive at ports 1 then 2 with matching data.
- Starvation: port 0 continuous writes, port 3 one read, MAX_WAIT=8 → port 3 urgent after 8 stalled cycles; accepted within 1 grant; counter back to 0.
- Lock hold: port 2 locked and stalled; port 0 raises a request → core_addr stays port 2's until its accept; port 0 accepted next.
- FIFO full: RD_DEPTH=4, 5 back-to-back reads from port 1, core_ack withheld → 4 accepts; 5th blocked; port 0 write still accepted; 5th accepted the cycle after the first core_ack.
- Reset with 2 reads outstanding, then core_ack pulse → no req_ack; err_orphan_ack=1 until next reset.
